// File: rtl/fir_out_stage.sv
// FIR output stage: round-half-up, drop FRAC_SHIFT bits, saturate to OUT_W,
// then buffer in a small FIFO behind a valid/ready interface with a saturation counter.
module fir_out_stage #(
  parameter int IN_W       = 26,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [15:0]      sat_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int RW = IN_W + 1;

  localparam logic signed [RW-1:0] SAT_HI = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_LO = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [RW-1:0] HALF   = {{(RW-1){1'b0}}, 1'b1} << (FRAC_SHIFT-1);

  logic signed [RW-1:0] in_ext;
  logic signed [RW-1:0] sum_w;
  logic signed [RW-1:0] r_w;

  logic signed [RW-1:0] s1_r_reg;
  logic                 s1_valid_reg;
  logic                 run_reg;

  logic [OUT_W-1:0]     mem_reg [DEPTH];
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic [CW-1:0]        count_next;
  logic [15:0]          sat_count_reg;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 sat_hi;
  logic                 sat_lo;
  logic                 sat_flag;
  logic [OUT_W-1:0]     wdata;
  logic [DEPTH-1:0]     we;

  // One extra bit of headroom so adding the rounding constant cannot overflow.
  assign in_ext = {in_data[IN_W-1], in_data};
  assign sum_w  = in_ext + HALF;
  assign r_w    = sum_w >>> FRAC_SHIFT;

  // Occupancy counts the sample held in S1, so a transfer always finds a free slot.
  assign in_ready  = run_reg && ((count_reg + CW'(s1_valid_reg)) < CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign push      = s1_valid_reg;
  assign sat_count = sat_count_reg;

  always_comb begin
    sat_hi   = (s1_r_reg > SAT_HI);
    sat_lo   = (s1_r_reg < SAT_LO);
    sat_flag = sat_hi || sat_lo;
    wdata    = s1_r_reg[OUT_W-1:0];
    if (sat_hi) begin
      wdata = SAT_HI[OUT_W-1:0];
    end else if (sat_lo) begin
      wdata = SAT_LO[OUT_W-1:0];
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg       <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_r_reg      <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      sat_count_reg <= '0;
    end else begin
      run_reg      <= 1'b1;
      s1_valid_reg <= accept;
      if (accept) begin
        s1_r_reg <= r_w;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
      if (clr_cnt) begin
        sat_count_reg <= '0;
      end else if (push && sat_flag && (sat_count_reg != 16'hFFFF)) begin
        sat_count_reg <= sat_count_reg + 16'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = push && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Storage needs no reset: out_data is gated by the occupancy count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we[i]) begin
        mem_reg[i] <= wdata;
      end
    end
  end

  assign out_data = out_valid ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_fir_out_stage.sv
// Self-checking bench for fir_out_stage: scenario tasks compared against a
// queue-based reference built from the rounding/saturation arithmetic.
module tb_fir_out_stage;

  localparam int DEPTH = 4;
  localparam int FS    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [25:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        clr_cnt;
  logic [15:0] sat_count;

  fir_out_stage #(.IN_W(26), .OUT_W(16), .FRAC_SHIFT(FS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: samples accepted but not yet delivered, oldest first.
  logic [15:0] exp_q[$];
  bit          last_acc;
  bit          pend_sat;
  bit          run_exp;
  logic [15:0] sat_model;

  // Per-cycle expectations and observations, refreshed by cycle().
  logic        e_ready, e_valid;
  logic [15:0] e_data, e_sat;
  logic        d_acc, d_pop;

  // {saturated, value}: floor((x + 2^(FS-1)) / 2^FS) clamped to int16.
  function automatic logic [16:0] ref_out(input logic [25:0] d);
    longint x, v, q;
    x = longint'($signed(d));
    v = x + (longint'(1) << (FS-1));
    if (v >= 0) q = v / 1024;
    else        q = -((-v + 1023) / 1024);
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_acc  = 0;
    pend_sat  = 0;
    run_exp   = 0;
    sat_model = 16'h0;
  endtask

  // Drive one cycle's inputs at the falling edge and predict the coming rising edge.
  task automatic cycle(input logic v, input logic [25:0] d, input logic ordy, input logic clr);
    logic [16:0] m;
    logic [15:0] tmp;
    bit m_acc, m_pop;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy; clr_cnt = clr;
    #1;
    e_ready = run_exp && (exp_q.size() < DEPTH);
    e_valid = (int'(exp_q.size()) - int'(last_acc)) > 0;
    e_data  = e_valid ? exp_q[0] : 16'h0;
    e_sat   = sat_model;
    d_acc   = in_valid && in_ready;
    d_pop   = out_valid && out_ready;
    m_acc   = v && e_ready;
    m_pop   = e_valid && ordy;
    if (m_pop) tmp = exp_q.pop_front();
    if (clr) sat_model = 16'h0;
    else if (pend_sat && sat_model != 16'hFFFF) sat_model = sat_model + 16'd1;
    pend_sat = 0;
    if (m_acc) begin
      m = ref_out(d);
      exp_q.push_back(m[15:0]);
      pend_sat = m[16];
    end
    last_acc = m_acc;
    run_exp  = 1;
    if (d_pop) $display("xfer out_data=%0d sat_count=%0d", $signed(out_data), sat_count);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_data = 26'h1234; out_ready = 1'b1; clr_cnt = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
        n_fail++;
        $display("FAIL reset_hold got rdy=%b vld=%b data=%h sat=%h want 0/0/0000/0000",
                 in_ready, out_valid, out_data, sat_count);
      end
    end
    @(posedge clk); #2; rst = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ready got %b want 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 26'h0, 1'b1, 1'b0);
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {e_ready, e_valid, e_data, e_sat}) begin
        n_fail++;
        $display("FAIL reset_after got %b/%b/%h/%h want %b/%b/%h/%h", in_ready, out_valid,
                 out_data, sat_count, e_ready, e_valid, e_data, e_sat);
      end
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_up got %b want 1", in_ready);
    end
  endtask

  task automatic test_rounding();
    int vals[6] = '{1536, -1536, 511, 512, -512, -513};
    int outs[6] = '{2, -1, 0, 1, 0, -1};
    logic [25:0] d;
    logic [15:0] want;
    for (int j = 0; j < 10; j++) begin
      d = 26'h0;
      if (j < 6) d = 26'(vals[j]);
      cycle(j < 6, d, 1'b1, 1'b0);
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {e_ready, e_valid, e_data, e_sat}) begin
        n_fail++;
        $display("FAIL rounding_model j=%0d got %b/%b/%h/%h want %b/%b/%h/%h", j, in_ready,
                 out_valid, out_data, sat_count, e_ready, e_valid, e_data, e_sat);
      end
      want = 16'h0;
      if (j >= 2 && j < 8) want = 16'(outs[j-2]);
      n_cmp++;
      if ({out_valid, out_data} !== {(j >= 2 && j < 8), want}) begin
        n_fail++;
        $display("FAIL rounding_latency j=%0d got vld=%b data=%h want vld=%b data=%h",
                 j, out_valid, out_data, (j >= 2 && j < 8), want);
      end
    end
    n_cmp++;
    if (sat_count !== 16'h0) begin
      n_fail++; $display("FAIL rounding_sat got %0d want 0", sat_count);
    end
  endtask

  task automatic test_saturation();
    logic        sv[9] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
    logic [25:0] sd[9] = '{26'h1FFFFFF, 26'h2000000, 0, 0, 0, 26'h1FFFFFF, 0, 0, 0};
    logic        sc[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [15:0] se[9] = '{0, 0, 16'h7FFF, 16'h8000, 0, 0, 0, 16'h7FFF, 0};
    logic [15:0] ss[9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
    for (int j = 0; j < 9; j++) begin
      cycle(sv[j], sd[j], 1'b1, sc[j]);
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {e_ready, e_valid, e_data, e_sat}) begin
        n_fail++;
        $display("FAIL saturation_model j=%0d got %b/%b/%h/%h want %b/%b/%h/%h", j, in_ready,
                 out_valid, out_data, sat_count, e_ready, e_valid, e_data, e_sat);
      end
      if (j == 2 || j == 3 || j == 7) begin
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, se[j]}) begin
          n_fail++;
          $display("FAIL saturation_value j=%0d got vld=%b data=%h want 1/%h", j, out_valid,
                   out_data, se[j]);
        end
      end
      if (j >= 4) begin
        n_cmp++;
        if (sat_count !== ss[j]) begin
          n_fail++; $display("FAIL saturation_count j=%0d got %0d want %0d", j, sat_count, ss[j]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [25:0] data[10];
    logic [25:0] d;
    int idx = 0;
    int pops = 0;
    int guard = 0;
    for (int i = 0; i < 10; i++) data[i] = 26'($urandom);
    for (int j = 0; j < 10; j++) begin
      cycle(1'b1, data[idx], 1'b0, 1'b0);
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {e_ready, e_valid, e_data, e_sat}) begin
        n_fail++;
        $display("FAIL backpressure_hold j=%0d got %b/%b/%h/%h want %b/%b/%h/%h", j, in_ready,
                 out_valid, out_data, sat_count, e_ready, e_valid, e_data, e_sat);
      end
      if (d_acc) idx++;
    end
    n_cmp++;
    if ({idx, in_ready} !== {32'd4, 1'b0}) begin
      n_fail++; $display("FAIL backpressure_accepted got %0d rdy=%b want 4 rdy=0", idx, in_ready);
    end
    while (!(idx == 10 && exp_q.size() == 0) && guard < 60) begin
      guard++;
      d = (idx < 10) ? data[idx] : 26'h0;
      cycle(idx < 10, d, 1'b1, 1'b0);
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {e_ready, e_valid, e_data, e_sat}) begin
        n_fail++;
        $display("FAIL backpressure_drain got %b/%b/%h/%h want %b/%b/%h/%h", in_ready,
                 out_valid, out_data, sat_count, e_ready, e_valid, e_data, e_sat);
      end
      if (d_acc) idx++;
      if (d_pop) pops++;
    end
    n_cmp++;
    if (pops + 0 !== 10) begin
      n_fail++; $display("FAIL backpressure_delivered got %0d want 10 (guard %0d)", pops, guard);
    end
  endtask

  task automatic test_throughput();
    for (int j = 0; j < 70; j++) begin
      cycle(j < 64, 26'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {e_ready, e_valid, e_data, e_sat}) begin
        n_fail++;
        $display("FAIL throughput_model j=%0d got %b/%b/%h/%h want %b/%b/%h/%h", j, in_ready,
                 out_valid, out_data, sat_count, e_ready, e_valid, e_data, e_sat);
      end
      n_cmp++;
      if ((j < 64 && in_ready !== 1'b1) || d_pop !== (j >= 2 && j < 66)) begin
        n_fail++;
        $display("FAIL throughput_stream j=%0d got rdy=%b pop=%b want rdy=1 pop=%b", j,
                 in_ready, d_pop, (j >= 2 && j < 66));
      end
    end
  endtask

  task automatic test_random();
    logic [25:0] d = 26'h0;
    logic v = 1'b0;
    for (int j = 0; j < 410; j++) begin
      if (!v || d_acc) begin
        v = (j < 400) && ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       d = 26'h1FFFFFF - 26'($urandom_range(0, 2000));
          1:       d = 26'h2000000 + 26'($urandom_range(0, 2000));
          default: d = 26'($urandom);
        endcase
      end
      cycle(v, d, (j >= 400) || ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {e_ready, e_valid, e_data, e_sat}) begin
        n_fail++;
        $display("FAIL random j=%0d got %b/%b/%h/%h want %b/%b/%h/%h", j, in_ready,
                 out_valid, out_data, sat_count, e_ready, e_valid, e_data, e_sat);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int j = 0; j < 4; j++) begin
      cycle(j < 3, 26'($urandom_range(0, 1000000)), 1'b0, 1'b0);
    end
    @(posedge clk); #2;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_before got vld=%b want 1", out_valid);
    end
    rst = 1'b0; #1;
    n_cmp++;
    if ({in_ready, out_valid, out_data, sat_count} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL midreset_drop got %b/%b/%h/%h want 0/0/0000/0000", in_ready, out_valid,
               out_data, sat_count);
    end
    model_reset();
    #20;
    @(posedge clk); #2; rst = 1'b1;
    for (int j = 0; j < 12; j++) begin
      cycle(j == 6, 26'h0000C00, 1'b1, 1'b0);
      n_cmp++;
      if ({in_ready, out_valid, out_data, sat_count} !== {e_ready, e_valid, e_data, e_sat}) begin
        n_fail++;
        $display("FAIL midreset_after j=%0d got %b/%b/%h/%h want %b/%b/%h/%h", j, in_ready,
                 out_valid, out_data, sat_count, e_ready, e_valid, e_data, e_sat);
      end
      n_cmp++;
      if ({out_valid, out_data} !== {(j == 8), (j == 8) ? 16'd3 : 16'd0}) begin
        n_fail++;
        $display("FAIL midreset_stale j=%0d got vld=%b data=%h want vld=%b", j, out_valid,
                 out_data, (j == 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_throughput();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
